magnetron_duty_ctrl: RTL and testbench

Registered, parametrised successor to the combinational magnetron ON/OFF logic in Control_Magnetron. It owns the cook state machine (idle / cooking / paused / done), latches a power level at start, and drives the magnetron with a tick-based duty cycle. It replaces the external set/reset latch, so the timer, keypad and door-sensor blocks connect straight to it. An optional pause/resume mode is selected at compile time.

---
 rtl/magnetron_duty_ctrl.sv | 124 ++++++++++++
 tb/tb_magnetron_duty_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_duty_ctrl.sv
// Registered magnetron cook controller: idle/cooking/paused/done FSM with tick-based duty cycle.
// Optional pause/resume mode: define MAG_PAUSE_RESUME_EN.
module magnetron_duty_ctrl #(
  parameter int DUTY_STEPS = 10,
  parameter int PWR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power_level,
  output logic             mag_on,
  output logic             cooking,
  output logic             paused,
  output logic             done,
  output logic [1:0]       state,
  output logic [PWR_W-1:0] phase
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [PWR_W-1:0] STEPS_V = PWR_W'(DUTY_STEPS);
  localparam logic [PWR_W-1:0] LAST_V  = PWR_W'(DUTY_STEPS - 1);

`ifdef MAG_PAUSE_RESUME_EN
  localparam state_e ABORT_DEST = PAUSED;
`else
  localparam state_e ABORT_DEST = IDLE;
`endif

  state_e           state_q, state_d;
  logic [PWR_W-1:0] phase_q, phase_d;
  logic [PWR_W-1:0] pl_q, pl_d;

  logic             abort;
  logic             start_ok;
  logic             resume_ok;
  logic [PWR_W-1:0] pl_clamped;

  always_comb begin
    abort      = !door_closed || !stopn;
    resume_ok  = !startn && stopn && door_closed && !timer_done;
    start_ok   = resume_ok && clearn;
    pl_clamped = (power_level > STEPS_V) ? STEPS_V : power_level;
  end

  // Each state branch lists its exits in priority order: clear, abort, timer, start.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pl_d    = pl_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = COOKING;
          phase_d = '0;
          pl_d    = pl_clamped;
        end
      end
      COOKING: begin
        if (!clearn) begin
          state_d = IDLE;
        end else if (abort) begin
          state_d = ABORT_DEST;
        end else if (timer_done) begin
          state_d = DONE;
        end else if (tick) begin
          phase_d = (phase_q == LAST_V) ? '0 : phase_q + PWR_W'(1);
        end
      end
      PAUSED: begin
        if (!clearn) begin
          state_d = IDLE;
        end else if (resume_ok) begin
          state_d = COOKING;
          phase_d = '0;
          pl_d    = pl_clamped;
        end
      end
      DONE: begin
        if (!clearn || !door_closed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pl_q    <= pl_d;
    end
  end

  // Door term is live so opening the door cuts the drive without waiting for an edge.
  assign mag_on  = (state_q == COOKING) && (phase_q < pl_q) && door_closed;
  assign cooking = (state_q == COOKING);
`ifdef MAG_PAUSE_RESUME_EN
  assign paused  = (state_q == PAUSED);
`else
  assign paused  = 1'b0;
`endif
  assign done    = (state_q == DONE);
  assign state   = state_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_magnetron_duty_ctrl.sv
// Bench for magnetron_duty_ctrl: cycle model plus directed scenarios with literal checkpoints.
module tb_magnetron_duty_ctrl;

  localparam int STEPS = 10;
  localparam int PW    = 4;

`ifdef MAG_PAUSE_RESUME_EN
  localparam int ABORT_ST = 2;
`else
  localparam int ABORT_ST = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          startn = 1'b1;
  logic          stopn = 1'b1;
  logic          clearn = 1'b1;
  logic          door_closed = 1'b1;
  logic          timer_done = 1'b0;
  logic [PW-1:0] power_level = '0;
  logic          mag_on, cooking, paused, done;
  logic [1:0]    state;
  logic [PW-1:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: 0 idle, 1 cooking, 2 paused, 3 done
  int m_st = 0;
  int m_ph = 0;
  int m_pl = 0;

  magnetron_duty_ctrl #(.DUTY_STEPS(STEPS), .PWR_W(PW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .timer_done(timer_done),
    .power_level(power_level), .mag_on(mag_on), .cooking(cooking),
    .paused(paused), .done(done), .state(state), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_pl(input int p);
    return (p > STEPS) ? STEPS : p;
  endfunction

  // Model advance at every rising edge using the inputs held across it.
  always @(posedge clk) begin
    bit go;
    go = !startn && stopn && door_closed && !timer_done;
    if (rst) begin
      m_st = 0; m_ph = 0; m_pl = 0;
    end else if (m_st == 0) begin
      if (go && clearn) begin m_st = 1; m_ph = 0; m_pl = clamp_pl(int'(power_level)); end
    end else if (m_st == 1) begin
      if (!clearn) m_st = 0;
      else if (!door_closed || !stopn) m_st = ABORT_ST;
      else if (timer_done) m_st = 3;
      else if (tick) m_ph = (m_ph + 1) % STEPS;
    end else if (m_st == 2) begin
      if (!clearn) m_st = 0;
      else if (go) begin m_st = 1; m_ph = 0; m_pl = clamp_pl(int'(power_level)); end
    end else begin
      if (!clearn || !door_closed) m_st = 0;
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk) begin
    check("state", int'(state), m_st);
    check("phase", int'(phase), m_ph);
    check("mag_on", int'(mag_on), int'(m_st == 1 && m_ph < m_pl && door_closed));
    check("cooking", int'(cooking), int'(m_st == 1));
    check("paused", int'(paused), int'(m_st == 2));
    check("done", int'(done), int'(m_st == 3));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  task automatic start_cook(input int pl);
    power_level = PW'(pl);
    startn = 1'b0; cyc(1);
    startn = 1'b1;
  endtask

  task automatic clear_all();
    clearn = 1'b0; cyc(1);
    clearn = 1'b1;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_mag", int'(mag_on), 0);

    // Full power
    start_cook(10);
    check("full_cooking", int'(cooking), 1);
    check("full_mag", int'(mag_on), 1);
    do_ticks(10);
    check("full_wrap_phase", int'(phase), 0);
    do_ticks(15);
    check("full_phase25", int'(phase), 5);
    check("full_mag25", int'(mag_on), 1);
    clear_all();
    check("clear_idle", int'(state), 0);

    // Power 3
    start_cook(3);
    do_ticks(2);
    check("p3_ph2_on", int'(mag_on), 1);
    do_ticks(1);
    check("p3_ph3_off", int'(mag_on), 0);
    do_ticks(6);
    check("p3_ph9_off", int'(mag_on), 0);
    do_ticks(1);
    check("p3_wrap_on", int'(mag_on), 1);
    do_ticks(10);
    clear_all();

    // Power 15 clamps to 10
    start_cook(15);
    do_ticks(9);
    check("p15_ph9_on", int'(mag_on), 1);
    do_ticks(3);
    clear_all();

    // Door opened at phase 5
    start_cook(10);
    do_ticks(5);
    door_closed = 1'b0; #1;
    check("door_comb_off", int'(mag_on), 0);
    cyc(1);
    check("door_state", int'(state), ABORT_ST);
    door_closed = 1'b1; cyc(1);
    start_cook(10);
    check("door_restart_cook", int'(cooking), 1);
    check("door_restart_phase", int'(phase), 0);

    // Timer done, start ignored, then clear
    do_ticks(2);
    timer_done = 1'b1; tick = 1'b1; cyc(1);
    timer_done = 1'b0; tick = 1'b0;
    check("td_done", int'(done), 1);
    check("td_mag", int'(mag_on), 0);
    check("td_phase_held", int'(phase), 2);
    startn = 1'b0; cyc(2); startn = 1'b1;
    check("td_start_ignored", int'(state), 3);
    clear_all();
    check("td_clear", int'(state), 0);

    // Simultaneous events in IDLE
    startn = 1'b0; clearn = 1'b0; cyc(1);
    clearn = 1'b1; startn = 1'b1;
    check("idle_start_clear", int'(state), 0);
    door_closed = 1'b0; startn = 1'b0; cyc(1);
    startn = 1'b1; door_closed = 1'b1;
    check("idle_start_door", int'(state), 0);

    // Stop and timer_done together: abort wins
    start_cook(6);
    do_ticks(1);
    stopn = 1'b0; timer_done = 1'b1; cyc(1);
    stopn = 1'b1; timer_done = 1'b0;
    check("stop_td_state", int'(state), ABORT_ST);
    check("stop_td_mag", int'(mag_on), 0);
`ifdef MAG_PAUSE_RESUME_EN
    timer_done = 1'b1; cyc(1); timer_done = 1'b0;
    check("paused_td_hold", int'(state), 2);
    start_cook(4);
    check("resume_phase", int'(phase), 0);
    do_ticks(4);
    check("resume_relatch", int'(mag_on), 0);
`endif
    clear_all();

    // Reset mid-cook
    start_cook(10);
    do_ticks(3);
    check("pre_rst_mag", int'(mag_on), 1);
    rst = 1'b1; cyc(1);
    check("rst_mid_state", int'(state), 0);
    check("rst_mid_phase", int'(phase), 0);
    check("rst_mid_mag", int'(mag_on), 0);
    rst = 1'b0;
    start_cook(2);
    do_ticks(1);
    check("relatch_ph1_on", int'(mag_on), 1);
    do_ticks(1);
    check("relatch_ph2_off", int'(mag_on), 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
